// File: rtl/dac_sample_sched.sv
// Per-frame sample fetch for the I2S DAC driver: ch0 then ch1, one-cycle ack each, underrun substitution after TIMEOUT.
// Latency: matching transfer -> ack next cycle; s_ready only in FETCH states, dropped while a pop restart is pending.
module dac_sample_sched #(
  parameter int TIMEOUT   = 24,
  parameter bit HOLD_LAST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pop_i,
  input  logic [23:0]      s_data_i,
  input  logic             s_lr_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [23:0]      data_o,
  output logic             lrck_o,
  output logic             ack_o,
  input  logic             mute_i,
  input  logic             clr_stats_i,
  output logic             underrun_o,
  output logic [CNT_W-1:0] underrun_cnt_o,
  output logic [CNT_W-1:0] slip_cnt_o,
  output logic             late_o
);

  typedef enum logic [2:0] {IDLE, FETCH0, ACK0, FETCH1, ACK1} state_t;

  localparam logic [4:0] TMO_LAST = 5'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [4:0]  tmo_cnt;
  logic [23:0] smp, hold0, hold1, data_q;
  logic        sub, lrck_q;
  logic        fetch, acking, ch, xfer, match, expire, slip;

  assign fetch  = (state == FETCH0) || (state == FETCH1);
  assign acking = (state == ACK0) || (state == ACK1);
  assign ch     = (state == FETCH1) || (state == ACK1);
  assign xfer   = s_valid_i && s_ready_o;
  assign match  = xfer && (s_lr_i == ch);
  assign slip   = xfer && (s_lr_i != ch);
  assign expire = fetch && !match && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      FETCH0:  if (match || expire) state_nxt = ACK0;
      ACK0:    state_nxt = FETCH1;
      FETCH1:  if (match || expire) state_nxt = ACK1;
      ACK1:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A pop always (re)starts the frame; any ack in this cycle is still issued.
    if (pop_i) state_nxt = FETCH0;
  end

  always_comb begin
    s_ready_o  = fetch && !pop_i && !rst;
    ack_o      = acking && !rst;
    underrun_o = acking && sub && !rst;
    late_o     = pop_i && (state != IDLE) && !rst;
    lrck_o     = lrck_q;
    data_o     = data_q;
    if (rst) begin
      lrck_o = 1'b0;
      data_o = '0;
    end else if (acking) begin
      lrck_o = ch;
      data_o = mute_i ? '0 : smp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt        <= '0;
      smp            <= '0;
      sub            <= 1'b0;
      hold0          <= '0;
      hold1          <= '0;
      data_q         <= '0;
      lrck_q         <= 1'b0;
      underrun_cnt_o <= '0;
      slip_cnt_o     <= '0;
    end else begin
      if (fetch && !pop_i && !match && !expire) tmo_cnt <= tmo_cnt + 5'd1;
      else                                      tmo_cnt <= '0;

      if (match) begin
        smp <= s_data_i;
        sub <= 1'b0;
      end else if (expire) begin
        smp <= HOLD_LAST ? (ch ? hold1 : hold0) : '0;
        sub <= 1'b1;
      end

      // Hold tracks real stream samples even when muted, so unmute-then-underrun repeats audio, not silence.
      if (ack_o) begin
        data_q <= data_o;
        lrck_q <= ch;
        if (!sub) begin
          if (ch) hold1 <= smp;
          else    hold0 <= smp;
        end
      end

      if (clr_stats_i) begin
        underrun_cnt_o <= '0;
        slip_cnt_o     <= '0;
      end else begin
        if (underrun_o && (underrun_cnt_o != {CNT_W{1'b1}}))
          underrun_cnt_o <= underrun_cnt_o + 1'b1;
        if (slip && (slip_cnt_o != {CNT_W{1'b1}}))
          slip_cnt_o <= slip_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dac_sample_sched.sv
// Bench for dac_sample_sched: directed vector table, hand-written corner sequences, then random traffic vs a frame model.
module tb_dac_sample_sched;

  logic        clk = 1'b0;
  logic        rst, pop, slr, svld, mute, clr;
  logic [23:0] sd;

  logic        a_rdy, a_lr, a_ack, a_und, a_late;
  logic [23:0] a_d;
  logic [15:0] a_ucnt, a_scnt;
  logic        b_rdy, b_lr, b_ack, b_und, b_late;
  logic [23:0] b_d;
  logic [3:0]  b_ucnt, b_scnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dac_sample_sched dut_a (
    .clk(clk), .rst(rst), .pop_i(pop), .s_data_i(sd), .s_lr_i(slr), .s_valid_i(svld),
    .s_ready_o(a_rdy), .data_o(a_d), .lrck_o(a_lr), .ack_o(a_ack), .mute_i(mute),
    .clr_stats_i(clr), .underrun_o(a_und), .underrun_cnt_o(a_ucnt), .slip_cnt_o(a_scnt),
    .late_o(a_late)
  );

  dac_sample_sched #(.TIMEOUT(5), .HOLD_LAST(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .pop_i(pop), .s_data_i(sd), .s_lr_i(slr), .s_valid_i(svld),
    .s_ready_o(b_rdy), .data_o(b_d), .lrck_o(b_lr), .ack_o(b_ack), .mute_i(mute),
    .clr_stats_i(clr), .underrun_o(b_und), .underrun_cnt_o(b_ucnt), .slip_cnt_o(b_scnt),
    .late_o(b_late)
  );

  // Frame-level model: mode 0 idle, 1 waiting for a sample of channel ch, 2 presenting it.
  typedef struct {
    int          mode;
    bit          ch;
    int          waited;
    logic [23:0] pend;
    bit          sub;
    logic [23:0] hold0, hold1, last_d;
    bit          last_lr;
    int          ucnt, scnt;
  } mstate_t;

  typedef struct {
    bit          ready, ack, lrck, und, late;
    logic [23:0] data;
  } mout_t;

  mstate_t ma, mb;
  mout_t   ea, eb;

  function automatic mstate_t m_reset();
    mstate_t n;
    n.mode = 0; n.ch = 1'b0; n.waited = 0; n.pend = '0; n.sub = 1'b0;
    n.hold0 = '0; n.hold1 = '0; n.last_d = '0; n.last_lr = 1'b0;
    n.ucnt = 0; n.scnt = 0;
    return n;
  endfunction

  function automatic mout_t m_eval(mstate_t m);
    mout_t o;
    o.ready = 1'b0; o.ack = 1'b0; o.lrck = 1'b0; o.und = 1'b0; o.late = 1'b0; o.data = '0;
    if (!rst) begin
      o.ready = (m.mode == 1) && !pop;
      o.ack   = (m.mode == 2);
      o.und   = o.ack && m.sub;
      o.late  = pop && (m.mode != 0);
      o.lrck  = o.ack ? m.ch : m.last_lr;
      o.data  = o.ack ? (mute ? 24'h0 : m.pend) : m.last_d;
    end
    return o;
  endfunction

  function automatic mstate_t m_next(mstate_t m, mout_t o, int t, bit h, int maxc);
    mstate_t n = m;
    bit      got;
    if (rst) return m_reset();
    got = o.ready && svld && (slr == m.ch);
    if (clr) begin
      n.ucnt = 0; n.scnt = 0;
    end else begin
      if (o.und && m.ucnt < maxc) n.ucnt = m.ucnt + 1;
      if (o.ready && svld && !got && m.scnt < maxc) n.scnt = m.scnt + 1;
    end
    if (o.ack) begin
      n.last_d = o.data; n.last_lr = m.ch;
      if (!m.sub) begin
        if (m.ch) n.hold1 = m.pend;
        else      n.hold0 = m.pend;
      end
    end
    if (pop) begin
      n.mode = 1; n.ch = 1'b0; n.waited = 0;
    end else if (m.mode == 1) begin
      if (got) begin
        n.mode = 2; n.pend = sd; n.sub = 1'b0;
      end else if (m.waited == t - 1) begin
        n.mode = 2; n.sub = 1'b1;
        n.pend = h ? (m.ch ? m.hold1 : m.hold0) : 24'h0;
      end else begin
        n.waited = m.waited + 1;
      end
    end else if (m.mode == 2) begin
      if (!m.ch) begin
        n.mode = 1; n.ch = 1'b1; n.waited = 0;
      end else begin
        n.mode = 0;
      end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tb_begin();
    #3;
    ea = m_eval(ma);
    eb = m_eval(mb);
  endtask

  task automatic tb_end();
    @(posedge clk);
    ma = m_next(ma, ea, 24, 1'b1, 65535);
    mb = m_next(mb, eb, 5, 1'b0, 15);
    #1;
  endtask

  task automatic set_in(input bit p, input bit v, input bit l, input logic [23:0] d);
    pop = p; svld = v; slr = l; sd = d;
  endtask

  task automatic cyc(input bit p, input bit v, input bit l, input logic [23:0] d);
    set_in(p, v, l, d);
    tb_begin();
    tb_end();
  endtask

  typedef struct {
    bit          pop, vld, lr, mute;
    logic [23:0] d;
    bit          e_rdy, e_ack, e_lr;
    logic [23:0] e_d;
  } vec_t;

  function automatic vec_t mkv(bit p, bit v, bit l, bit m, logic [23:0] d,
                               bit er, bit ek, bit el, logic [23:0] ed);
    vec_t x;
    x.pop = p; x.vld = v; x.lr = l; x.mute = m; x.d = d;
    x.e_rdy = er; x.e_ack = ek; x.e_lr = el; x.e_d = ed;
    return x;
  endfunction

  vec_t tbl[18];
  int          ka[2], kb[2], na, nb;
  logic [23:0] da[2], db[2];
  bit          ua[2], ub[2];

  initial begin
    tbl[0]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000);
    tbl[1]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 24'h123456, 1'b1, 1'b0, 1'b0, 24'h000000);
    tbl[2]  = mkv(1'b0, 1'b1, 1'b1, 1'b0, 24'hABCDEF, 1'b0, 1'b1, 1'b0, 24'h123456);
    tbl[3]  = mkv(1'b0, 1'b1, 1'b1, 1'b0, 24'hABCDEF, 1'b1, 1'b0, 1'b0, 24'h123456);
    tbl[4]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 24'hABCDEF);
    tbl[5]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'hABCDEF);
    tbl[6]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'hABCDEF);
    tbl[7]  = mkv(1'b0, 1'b1, 1'b1, 1'b0, 24'h111111, 1'b1, 1'b0, 1'b1, 24'hABCDEF);
    tbl[8]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 24'h222222, 1'b1, 1'b0, 1'b1, 24'hABCDEF);
    tbl[9]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h222222);
    tbl[10] = mkv(1'b0, 1'b1, 1'b1, 1'b0, 24'h000333, 1'b1, 1'b0, 1'b0, 24'h222222);
    tbl[11] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 24'h000333);
    tbl[12] = mkv(1'b1, 1'b0, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h000333);
    tbl[13] = mkv(1'b0, 1'b1, 1'b0, 1'b1, 24'h7FFFFF, 1'b1, 1'b0, 1'b1, 24'h000333);
    tbl[14] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h000000);
    tbl[15] = mkv(1'b0, 1'b1, 1'b1, 1'b1, 24'h800000, 1'b1, 1'b0, 1'b0, 24'h000000);
    tbl[16] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b1, 24'h000000);
    tbl[17] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h000000);

    ma = m_reset(); mb = m_reset();
    rst = 1'b1; mute = 1'b0; clr = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 24'h0);
    repeat (2) begin tb_begin(); tb_end(); end
    rst = 1'b0;

    tb_begin();
    chk("reset_ready", 32'(a_rdy), 32'd0);
    chk("reset_ack",   32'(a_ack), 32'd0);
    chk("reset_data",  32'(a_d),   32'd0);
    chk("reset_lrck",  32'(a_lr),  32'd0);
    chk("reset_und",   32'(a_und), 32'd0);
    chk("reset_late",  32'(a_late), 32'd0);
    chk("reset_ucnt",  32'(a_ucnt), 32'd0);
    chk("reset_scnt",  32'(a_scnt), 32'd0);
    tb_end();

    for (int i = 0; i < 18; i++) begin
      set_in(tbl[i].pop, tbl[i].vld, tbl[i].lr, tbl[i].d);
      mute = tbl[i].mute;
      tb_begin();
      chk($sformatf("vec%0d_a_ready", i), 32'(a_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_a_ack", i),   32'(a_ack), 32'(tbl[i].e_ack));
      chk($sformatf("vec%0d_a_lrck", i),  32'(a_lr),  32'(tbl[i].e_lr));
      chk($sformatf("vec%0d_a_data", i),  32'(a_d),   32'(tbl[i].e_d));
      chk($sformatf("vec%0d_b_ack", i),   32'(b_ack), 32'(tbl[i].e_ack));
      chk($sformatf("vec%0d_b_data", i),  32'(b_d),   32'(tbl[i].e_d));
      chk($sformatf("vec%0d_a_und", i),   32'(a_und), 32'd0);
      tb_end();
    end
    mute = 1'b0;
    tb_begin();
    chk("slip_cnt_a", 32'(a_scnt), 32'd1);
    chk("slip_cnt_b", 32'(b_scnt), 32'd1);
    chk("no_underrun_a", 32'(a_ucnt), 32'd0);
    tb_end();

    // Underrun: dut_a holds the muted-but-real samples, dut_b substitutes zero.
    cyc(1'b1, 1'b0, 1'b0, 24'h0);
    na = 0; nb = 0;
    for (int j = 0; j < 2; j++) begin
      ka[j] = -1; kb[j] = -1; da[j] = '0; db[j] = '0; ua[j] = 1'b0; ub[j] = 1'b0;
    end
    for (int k = 1; k < 60; k++) begin
      set_in(1'b0, 1'b0, 1'b0, 24'h0);
      tb_begin();
      if (a_ack && na < 2) begin ka[na] = k; da[na] = a_d; ua[na] = a_und; na++; end
      if (b_ack && nb < 2) begin kb[nb] = k; db[nb] = b_d; ub[nb] = b_und; nb++; end
      tb_end();
    end
    chk("und_a_acks", 32'(na), 32'd2);
    chk("und_a_lat0", 32'(ka[0]), 32'd25);
    chk("und_a_lat1", 32'(ka[1]), 32'd50);
    chk("und_a_hold0", 32'(da[0]), 32'h7FFFFF);
    chk("und_a_hold1", 32'(da[1]), 32'h800000);
    chk("und_a_pulse", 32'({ua[1], ua[0]}), 32'd3);
    chk("und_b_acks", 32'(nb), 32'd2);
    chk("und_b_lat0", 32'(kb[0]), 32'd6);
    chk("und_b_lat1", 32'(kb[1]), 32'd12);
    chk("und_b_zero", 32'({db[1] | db[0]}), 32'd0);
    chk("und_b_pulse", 32'({ub[1], ub[0]}), 32'd3);
    tb_begin();
    chk("und_cnt_a", 32'(a_ucnt), 32'd2);
    chk("und_cnt_b", 32'(b_ucnt), 32'd2);
    tb_end();

    // Late pop while fetching channel 1 restarts the frame at channel 0.
    cyc(1'b1, 1'b0, 1'b0, 24'h0);
    cyc(1'b0, 1'b1, 1'b0, 24'h000AAA);
    cyc(1'b0, 1'b0, 1'b0, 24'h0);
    set_in(1'b1, 1'b0, 1'b0, 24'h0);
    tb_begin();
    chk("late_a", 32'(a_late), 32'd1);
    chk("late_b", 32'(b_late), 32'd1);
    chk("late_ready", 32'(a_rdy), 32'd0);
    tb_end();
    set_in(1'b0, 1'b1, 1'b0, 24'h000BBB);
    tb_begin();
    chk("late_refetch_ready", 32'(a_rdy), 32'd1);
    chk("late_clear", 32'(a_late), 32'd0);
    tb_end();
    set_in(1'b0, 1'b0, 1'b0, 24'h0);
    tb_begin();
    chk("late_ack", 32'(a_ack), 32'd1);
    chk("late_ack_lrck", 32'(a_lr), 32'd0);
    chk("late_ack_data", 32'(a_d), 32'h000BBB);
    chk("late_ack_b", 32'(b_ack), 32'd1);
    tb_end();
    cyc(1'b0, 1'b1, 1'b1, 24'h000CCC);
    set_in(1'b0, 1'b0, 1'b0, 24'h0);
    tb_begin();
    chk("late_ack1_lrck", 32'(a_lr), 32'd1);
    chk("late_ack1_data", 32'(a_d), 32'h000CCC);
    tb_end();

    // Saturation: wrong-channel samples flood FETCH0 of four frames.
    for (int f = 0; f < 4; f++) begin
      cyc(1'b1, 1'b0, 1'b0, 24'h0);
      for (int j = 1; j < 32; j++) cyc(1'b0, 1'b1, 1'b1, 24'h0F0F0F);
    end
    set_in(1'b0, 1'b0, 1'b0, 24'h0);
    tb_begin();
    chk("sat_slip_b", 32'(b_scnt), 32'd15);
    chk("sat_und_b", 32'(b_ucnt), 32'd6);
    chk("slip_cnt_a_97", 32'(a_scnt), 32'd97);
    chk("und_cnt_a_6", 32'(a_ucnt), 32'd6);
    tb_end();

    cyc(1'b1, 1'b0, 1'b0, 24'h0);
    clr = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 24'h0F0F0F);
    clr = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 24'h0);
    tb_begin();
    chk("clr_slip_a", 32'(a_scnt), 32'd0);
    chk("clr_slip_b", 32'(b_scnt), 32'd0);
    chk("clr_und_a", 32'(a_ucnt), 32'd0);
    chk("clr_und_b", 32'(b_ucnt), 32'd0);
    tb_end();
    repeat (60) cyc(1'b0, 1'b0, 1'b0, 24'h0);

    // Reset in FETCH1 with a sample offered: nothing consumed, no ack.
    cyc(1'b1, 1'b0, 1'b0, 24'h0);
    cyc(1'b0, 1'b1, 1'b0, 24'h000777);
    cyc(1'b0, 1'b0, 1'b0, 24'h0);
    rst = 1'b1;
    set_in(1'b0, 1'b1, 1'b1, 24'h000888);
    tb_begin();
    chk("rst_ready", 32'(a_rdy), 32'd0);
    chk("rst_ack", 32'(a_ack), 32'd0);
    tb_end();
    rst = 1'b0;
    for (int j = 0; j < 2; j++) begin
      tb_begin();
      chk("post_rst_ready", 32'(a_rdy), 32'd0);
      chk("post_rst_ack", 32'(a_ack), 32'd0);
      chk("post_rst_data", 32'(a_d), 32'd0);
      chk("post_rst_lrck", 32'(a_lr), 32'd0);
      chk("post_rst_cnts", 32'({a_ucnt, a_scnt}), 32'd0);
      chk("post_rst_b", 32'({b_rdy, b_ack, b_und, b_late, b_lr}), 32'd0);
      tb_end();
    end

    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 24'h0);
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      set_in($urandom_range(39) == 0, $urandom_range(9) < 6, 1'($urandom_range(1)),
             24'($urandom));
      mute = $urandom_range(9) == 0;
      clr  = $urandom_range(49) == 0;
      rst  = $urandom_range(299) == 0;
      tb_begin();
      chk("rnd_a_ready", 32'(a_rdy),  32'(ea.ready));
      chk("rnd_a_ack",   32'(a_ack),  32'(ea.ack));
      chk("rnd_a_lrck",  32'(a_lr),   32'(ea.lrck));
      chk("rnd_a_data",  32'(a_d),    32'(ea.data));
      chk("rnd_a_und",   32'(a_und),  32'(ea.und));
      chk("rnd_a_late",  32'(a_late), 32'(ea.late));
      chk("rnd_a_ucnt",  32'(a_ucnt), 32'(ma.ucnt));
      chk("rnd_a_scnt",  32'(a_scnt), 32'(ma.scnt));
      chk("rnd_b_ready", 32'(b_rdy),  32'(eb.ready));
      chk("rnd_b_ack",   32'(b_ack),  32'(eb.ack));
      chk("rnd_b_lrck",  32'(b_lr),   32'(eb.lrck));
      chk("rnd_b_data",  32'(b_d),    32'(eb.data));
      chk("rnd_b_und",   32'(b_und),  32'(eb.und));
      chk("rnd_b_late",  32'(b_late), 32'(eb.late));
      chk("rnd_b_ucnt",  32'(b_ucnt), 32'(mb.ucnt));
      chk("rnd_b_scnt",  32'(b_scnt), 32'(mb.scnt));
      tb_end();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
